// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline stall/flush controller for a 5-stage MIPS-style core.
// It generates the EN, CLR and bubble controls for the IF/ID, ID/EX and EX/MEM
// pipeline registers. It handles four cases:
//   - load-use hazards;
//   - a branch or jump resolved taken in EX;
//   - multi-cycle mul/div freezes of MDU_LAT cycles;
//   - SYSCALL, which halts the pipe until a go pulse arrives.
// All outputs are combinational from the FSM state, the done flag and the inputs.
// Optional build macro HAZARD_PERF_EN adds a saturating stall-cycle counter on
// stall_cycles. When the macro is undefined, stall_cycles is tied to zero.
module hazard_stall_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 3
) (
    input  logic        clk,
    input  logic        CLR,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_uses_rs,
    input  logic        ID_uses_rt,
    input  logic        EX_MemtoReg,
    input  logic [4:0]  EX_WbRegNum,
    input  logic        EX_branch_taken,
    input  logic        EX_mdu_start,
    input  logic        EX_SYSCALL,
    input  logic        go,
    output logic        PC_EN,
    output logic        IFID_EN,
    output logic        IFID_CLR,
    output logic        IDEX_EN,
    output logic        IDEX_CLR,
    output logic        IDEX_bb,
    output logic        EXMEM_bb,
    output logic        mdu_busy,
    output logic        mdu_done,
    output logic        halted,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MDU  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // The start cycle is the first frozen cycle, so the MDU state counts down
    // from MDU_LAT-2 to 0, which gives MDU_LAT frozen cycles in total.
    localparam int              CNT_INIT = (MDU_LAT >= 2) ? (MDU_LAT - 2) : 0;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CNT_INIT);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    logic w_run;
    logic w_mdu_start;
    logic w_freeze;
    logic w_branch;
    logic w_lu_match;
    logic w_load_use;

    // Hazard classification in priority order: MDU start, then branch flush,
    // then load-use. Everything is gated by CLR so that reset forces the
    // default outputs.
    always_comb begin
        w_run       = !CLR && (r_state == ST_RUN);
        // On the done cycle the finishing MDU instruction is still in EX.
        // Ignoring its start bit here lets it advance instead of restarting.
        w_mdu_start = w_run && EX_mdu_start && !r_done;
        w_freeze    = !CLR && ((r_state == ST_MDU) || (r_state == ST_HALT) || w_mdu_start);
        w_branch    = w_run && !w_mdu_start && EX_branch_taken;
        w_lu_match  = EX_MemtoReg && (EX_WbRegNum != 5'd0) &&
                      ((ID_uses_rs && (ID_rs == EX_WbRegNum)) ||
                       (ID_uses_rt && (ID_rt == EX_WbRegNum)));
        w_load_use  = w_run && !w_mdu_start && !w_branch && w_lu_match;
    end

    // Pipeline-register controls derived from the classification above.
    always_comb begin
        PC_EN    = !(w_freeze || w_load_use);
        IFID_EN  = !(w_freeze || w_load_use);
        IFID_CLR = w_branch;
        IDEX_EN  = !w_freeze;
        IDEX_CLR = w_branch;
        IDEX_bb  = w_load_use;
        EXMEM_bb = w_freeze;
        mdu_busy = !CLR && ((r_state == ST_MDU) || w_mdu_start);
        mdu_done = w_run && r_done;
        halted   = !CLR && (r_state == ST_HALT);
    end

    // Control FSM: RUN / MDU countdown / HALT, plus the one-cycle done flag.
    always_ff @(posedge clk) begin
        if (CLR) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_done <= 1'b0;
                    if (w_mdu_start) begin
                        if (MDU_LAT == 1) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= ST_MDU;
                            r_cnt   <= CNT_LOAD;
                        end
                    end else if (EX_SYSCALL) begin
                        r_state <= ST_HALT;
                    end
                end
                ST_MDU: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_RUN;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_HALT: begin
                    if (go) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_cnt   <= '0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;

    // Count cycles lost to stalls (PC held) outside HALT, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (CLR) begin
            r_stall_cnt <= '0;
        end else if ((r_state != ST_HALT) && !PC_EN && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cnt;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl.
// It runs directed scenarios first and then randomized traffic. Every cycle is
// compared against a behavioural model kept in this file.
module tb_hazard_stall_ctrl;

    localparam int MDU_LAT = 4;
    localparam int CNT_W   = 3;

    // Output vector layout:
    // {PC_EN,IFID_EN,IFID_CLR,IDEX_EN,IDEX_CLR,IDEX_bb,EXMEM_bb,mdu_busy,mdu_done,halted}
    localparam logic [9:0] V_DEF    = 10'b1101000000;
    localparam logic [9:0] V_LU     = 10'b0001010000;
    localparam logic [9:0] V_FLUSH  = 10'b1111100000;
    localparam logic [9:0] V_FREEZE = 10'b0000001100;
    localparam logic [9:0] V_DONE   = 10'b1101000010;
    localparam logic [9:0] V_HALT   = 10'b0000001001;

    logic        clk = 1'b0;
    logic        CLR;
    logic [4:0]  ID_rs, ID_rt, EX_WbRegNum;
    logic        ID_uses_rs, ID_uses_rt, EX_MemtoReg, EX_branch_taken;
    logic        EX_mdu_start, EX_SYSCALL, go;
    logic        PC_EN, IFID_EN, IFID_CLR, IDEX_EN, IDEX_CLR, IDEX_bb;
    logic        EXMEM_bb, mdu_busy, mdu_done, halted;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .CLR(CLR),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
        .EX_MemtoReg(EX_MemtoReg), .EX_WbRegNum(EX_WbRegNum),
        .EX_branch_taken(EX_branch_taken), .EX_mdu_start(EX_mdu_start),
        .EX_SYSCALL(EX_SYSCALL), .go(go),
        .PC_EN(PC_EN), .IFID_EN(IFID_EN), .IFID_CLR(IFID_CLR), .IDEX_EN(IDEX_EN),
        .IDEX_CLR(IDEX_CLR), .IDEX_bb(IDEX_bb), .EXMEM_bb(EXMEM_bb),
        .mdu_busy(mdu_busy), .mdu_done(mdu_done), .halted(halted),
        .stall_cycles(stall_cycles)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model.
    // m_mode: 0 = running, 1 = mul/div in flight, 2 = halted.
    // m_left: frozen cycles still owed after the current one.
    int          m_mode = 0;
    int          m_left = 0;
    bit          m_done = 0;
    logic [31:0] m_stall = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        CLR = 0; ID_rs = 0; ID_rt = 0; ID_uses_rs = 0; ID_uses_rt = 0;
        EX_MemtoReg = 0; EX_WbRegNum = 0; EX_branch_taken = 0;
        EX_mdu_start = 0; EX_SYSCALL = 0; go = 0;
    endtask

    // One transaction.
    // 1. Inputs are already driven by the caller.
    // 2. Predict the outputs, compare, and print one line.
    // 3. Advance the clock and evolve the model.
    task automatic cycle(input string tag, output logic [9:0] obs);
        logic [9:0]  e;
        logic [31:0] e_stall;
        bit start, lu;
        #1;
        start = 0;
        lu = EX_MemtoReg && (EX_WbRegNum != 0) &&
             ((ID_uses_rs && ID_rs == EX_WbRegNum) || (ID_uses_rt && ID_rt == EX_WbRegNum));
        if (CLR)              e = V_DEF;
        else if (m_mode == 2) e = V_HALT;
        else if (m_mode == 1) e = V_FREEZE;
        else begin
            start = EX_mdu_start && !m_done;
            if (start)                e = V_FREEZE;
            else if (EX_branch_taken) e = V_FLUSH;
            else if (lu)              e = V_LU;
            else                      e = V_DEF;
            if (m_done) e[1] = 1'b1;
        end
`ifdef HAZARD_PERF_EN
        e_stall = m_stall;
`else
        e_stall = 32'd0;
`endif
        obs = {PC_EN, IFID_EN, IFID_CLR, IDEX_EN, IDEX_CLR, IDEX_bb,
               EXMEM_bb, mdu_busy, mdu_done, halted};
        check({tag, "/ctl"}, 32'(obs), 32'(e));
        check({tag, "/stall"}, stall_cycles, e_stall);
        $display("%s: ctl=%b exp=%b stall=%0d", tag, obs, e, stall_cycles);
        @(posedge clk);
        if (CLR) begin
            m_mode = 0; m_left = 0; m_done = 0; m_stall = 0;
        end else begin
            if (m_mode != 2 && !e[9] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            case (m_mode)
                2: if (go) m_mode = 0;
                1: begin
                    m_left--;
                    if (m_left == 0) begin m_mode = 0; m_done = 1; end
                end
                default: begin
                    m_done = 0;
                    if (start) begin
                        m_left = MDU_LAT - 1;
                        if (m_left == 0) m_done = 1;
                        else m_mode = 1;
                    end else if (EX_SYSCALL) m_mode = 2;
                end
            endcase
        end
        #1;
    endtask

    initial begin
        logic [9:0]  o;
        logic [31:0] s0;
        int          busy_n;

        // Reset. Take one unchecked edge so the counter leaves X first.
        set_idle();
        CLR = 1;
        @(posedge clk); #1;
        cycle("reset", o);
        check("reset_vec", 32'(o), 32'(V_DEF));
        CLR = 0;
        cycle("idle", o);

        // Load-use on rs = 8.
        EX_MemtoReg = 1; EX_WbRegNum = 8; ID_rs = 8; ID_uses_rs = 1;
        cycle("lu", o);
        check("lu_vec", 32'(o), 32'(V_LU));
        // Same stimulus with destination $0: no stall.
        EX_WbRegNum = 0; ID_rs = 0;
        cycle("lu_r0", o);
        check("lu_r0_vec", 32'(o), 32'(V_DEF));
        // Load-use via rt.
        EX_WbRegNum = 17; ID_rt = 17; ID_uses_rs = 0; ID_uses_rt = 1;
        cycle("lu_rt", o);
        check("lu_rt_vec", 32'(o), 32'(V_LU));
        // Branch over a load-use match.
        EX_branch_taken = 1;
        cycle("br_lu", o);
        check("br_lu_vec", 32'(o), 32'(V_FLUSH));
        set_idle();
        cycle("idle", o);

        // MDU with start held: MDU_LAT frozen cycles, then one done cycle.
        s0 = stall_cycles;
        EX_mdu_start = 1;
        busy_n = 0;
        for (int i = 0; i < MDU_LAT; i++) begin
            cycle("mdu", o);
            if (o[2]) busy_n++;
        end
        check("mdu_busy_cycles", busy_n, MDU_LAT);
        cycle("mdu_done", o);
        check("mdu_done_vec", 32'(o), 32'(V_DONE));
`ifdef HAZARD_PERF_EN
        check("mdu_stall_delta", stall_cycles - s0, 32'(MDU_LAT));
`else
        check("mdu_stall_off", stall_cycles, 32'd0);
`endif
        EX_mdu_start = 0;
        cycle("mdu_after", o);
        check("mdu_after_vec", 32'(o), 32'(V_DEF));

        // Reset on the second frozen cycle.
        EX_mdu_start = 1;
        cycle("mdu_rst1", o);
        CLR = 1;
        cycle("mdu_rst2", o);
        CLR = 0; EX_mdu_start = 0;
        cycle("mdu_rst3", o);
        check("mdu_rst_vec", 32'(o), 32'(V_DEF));
        check("mdu_rst_stall", stall_cycles, 32'd0);

        // SYSCALL halt, resumed by go after 5 cycles.
        EX_SYSCALL = 1;
        cycle("sys", o);
        EX_SYSCALL = 0;
        for (int i = 0; i < 5; i++) begin
            cycle("halt", o);
            check("halt_vec", 32'(o), 32'(V_HALT));
        end
        go = 1;
        cycle("go", o);
        check("go_vec", 32'(o), 32'(V_HALT));
        go = 0;
        cycle("resumed", o);
        check("resumed_vec", 32'(o), 32'(V_DEF));
        // go while running has no effect.
        go = 1;
        cycle("go_run", o);
        go = 0;
        cycle("go_run2", o);
        check("go_run_vec", 32'(o), 32'(V_DEF));

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            CLR             = ($urandom_range(0, 39) == 0);
            ID_rs           = 5'($urandom_range(0, 3));
            ID_rt           = 5'($urandom_range(0, 3));
            ID_uses_rs      = 1'($urandom);
            ID_uses_rt      = 1'($urandom);
            EX_MemtoReg     = 1'($urandom);
            EX_WbRegNum     = 5'($urandom_range(0, 3));
            EX_branch_taken = ($urandom_range(0, 4) == 0);
            EX_mdu_start    = ($urandom_range(0, 5) == 0);
            EX_SYSCALL      = ($urandom_range(0, 14) == 0);
            go              = ($urandom_range(0, 3) == 0);
            cycle("rnd", o);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline control unit that drives the EN, CLR and bubble (bb) inputs of the IF/ID, ID/EX and EX/MEM pipeline registers.
- Detects load-use hazards, flushes on a branch taken in EX, freezes the pipe for multi-cycle HI/LO (mul/div) operations, and halts on SYSCALL until resumed.
- Sits beside the decoder and consumes ID-stage operand fields and EX-stage control outputs.

Parameters:
- MDU_LAT, 4, number of frozen cycles for one mul/div op; must be >= 1.
- CNT_W, 3, width of the MDU countdown counter; must satisfy 2^CNT_W >= MDU_LAT.

Ports:
- clk  in  1  clock, rising edge.
- CLR  in  1  synchronous active-high reset.
- ID_rs  in  5  rs field of the instruction in ID.
- ID_rt  in  5  rt field of the instruction in ID.
- ID_uses_rs  in  1  ID instruction reads rs.
- ID_uses_rt  in  1  ID instruction reads rt.
- EX_MemtoReg  in  1  EX instruction is a load.
- EX_WbRegNum  in  5  EX destination register.
- EX_branch_taken  in  1  branch or jump in EX is resolved taken.
- EX_mdu_start  in  1  EX instruction is a multi-cycle mul/div.
- EX_SYSCALL  in  1  EX instruction is SYSCALL.
- go  in  1  resume pulse from halt.
- PC_EN  out  1  PC update enable.
- IFID_EN  out  1  IF/ID enable.
- IFID_CLR  out  1  IF/ID flush.
- IDEX_EN  out  1  ID/EX enable.
- IDEX_CLR  out  1  ID/EX flush.
- IDEX_bb  out  1  ID/EX bubble; takes effect only together with IDEX_EN.
- EXMEM_bb  out  1  EX/MEM bubble; EX/MEM EN is held at 1.
- mdu_busy  out  1  MDU freeze in progress.
- mdu_done  out  1  one-cycle pulse: MDU result may be written to HI/LO.
- halted  out  1  in HALT state.
- stall_cycles  out  32  performance counter (see Optional Feature).

Behaviour:
- States: RUN, MDU, HALT. Registers: state, cnt[CNT_W-1:0], done_r.
- All outputs are combinational from state, done_r and the inputs.
- Default outputs (RUN, no hazard): PC_EN=IFID_EN=IDEX_EN=1; all other outputs 0.
- While CLR=1, all outputs take the default values and all hazard inputs are ignored.
- On the CLR edge: state=RUN, cnt=0, done_r=0. This applies from any state, including mid-MDU and HALT.
- Priority in RUN, highest first: MDU start, branch flush, load-use.
- MDU start: condition is EX_mdu_start=1 and done_r=0.
  - Outputs that cycle: PC_EN=IFID_EN=IDEX_EN=0, EXMEM_bb=1, mdu_busy=1.
  - If MDU_LAT=1: next state RUN, done_r<=1.
  - Otherwise: next state MDU, cnt<=MDU_LAT-2.
- MDU state: outputs are the same freeze as MDU start.
  - cnt decrements by 1 each cycle.
  - When cnt=0: next state RUN, done_r<=1.
  - Total frozen cycles = MDU_LAT exactly.
- done_r=1 in RUN:
  - mdu_done=1.
  - The MDU instruction advances; EX_mdu_start is ignored this cycle.
  - done_r<=0 on the next edge.
- Branch flush: condition is EX_branch_taken=1.
  - IFID_CLR=1, IDEX_CLR=1; PC_EN stays 1 so the target loads.
  - Load-use detection is suppressed this cycle.
- Load-use: condition is EX_MemtoReg=1 and EX_WbRegNum!=0 and ((ID_uses_rs and ID_rs==EX_WbRegNum) or (ID_uses_rt and ID_rt==EX_WbRegNum)).
  - PC_EN=0, IFID_EN=0, IDEX_EN=1, IDEX_bb=1.
  - One bubble is inserted; re-evaluation the next cycle naturally clears the hazard.
- SYSCALL: EX_SYSCALL=1 in RUN, with no MDU start that cycle.
  - The current cycle proceeds per the rules above (flush and load-use still apply).
  - Next state HALT.
- HALT state: PC_EN=IFID_EN=IDEX_EN=0, EXMEM_bb=1, halted=1.
  - go=1: next state RUN; the go cycle itself is still frozen.
  - go in RUN or MDU is ignored.
  - Hazard inputs are ignored in HALT.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - stall_cycles increments by 1 on each clock edge where state!=HALT and CLR=0 and PC_EN=0.
  - Saturates at 32'hFFFFFFFF.
  - Reset to 0 by CLR.
- Undefined: stall_cycles is tied to 0 and no counter flops exist.

Test Plan:
- Load-use: EX_MemtoReg=1, EX_WbRegNum=8, ID_rs=8, ID_uses_rs=1 -> one cycle of PC_EN=0, IFID_EN=0, IDEX_bb=1, IDEX_EN=1. Same stimulus with EX_WbRegNum=0 -> no stall.
- Branch over load-use: EX_branch_taken=1 together with a load-use match -> IFID_CLR=IDEX_CLR=1, PC_EN=1, IDEX_bb=0.
- MDU, MDU_LAT=4: hold EX_mdu_start=1 -> mdu_busy=1 and EXMEM_bb=1 for exactly 4 cycles, then mdu_done=1 for 1 cycle with all EN=1, then RUN. With the macro defined, stall_cycles=4.
- Reset mid-MDU: CLR=1 on the 2nd frozen cycle -> next cycle state RUN, mdu_busy=0, mdu_done=0, stall_cycles=0.
- SYSCALL halt: EX_SYSCALL=1 for 1 cycle -> halted=1 from the next cycle. go=1 after 5 cycles -> halted=0 and EN=1 on the cycle after go. go asserted while in RUN -> no effect.
